// File: rtl/bcd_timer_chain_if.sv
// Bundle of control inputs and status/value outputs for bcd_timer_chain.
//   master: the controller/bench side (drives tick/start/stop/dir/load/
//           load_val/sft_clr/lap, observes count/disp/tc/running/done/lap_hold)
//   slave : the timer chain itself
interface bcd_timer_chain_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    tick;
  logic                    start;
  logic                    stop;
  logic                    dir;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    sft_clr;
  logic                    lap;
  logic [4*NUM_DIGITS-1:0] count;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    tc;
  logic                    running;
  logic                    done;
  logic                    lap_hold;

  modport master (
    output tick, start, stop, dir, load, load_val, sft_clr, lap,
    input  count, disp, tc, running, done, lap_hold
  );

  modport slave (
    input  tick, start, stop, dir, load, load_val, sft_clr, lap,
    output count, disp, tc, running, done, lap_hold
  );
endinterface

// File: rtl/bcd_timer_chain.sv
// Parametrised BCD counter chain with per-digit modulus, up/down counting,
// preset load, run/pause/done control, terminal-count pulse and lap freeze.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active-HIGH despite the name
//   bus   : bcd_timer_chain_if.slave (tick/start/stop/dir/load/load_val/
//           sft_clr/lap in; count/disp/tc/running/done/lap_hold out)
module bcd_timer_chain #(
  parameter int          NUM_DIGITS = 4,
  parameter logic [31:0] DIGIT_MAX  = 32'h0000_5959,
  parameter bit          WRAP       = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_timer_chain_if.slave  bus
);
  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   disp_q, disp_d;
  logic           tc_q, tc_d;
  logic           lap_hold_q, lap_hold_d;
  logic [W-1:0]   step_val;
  logic           step_term;
  logic           do_tick;

  // Saturate each loaded digit to its own modulus.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > DIGIT_MAX[4*i +: 4]) ? DIGIT_MAX[4*i +: 4]
                                                        : v[4*i +: 4];
    end
    return r;
  endfunction

  // One-tick step of the whole chain: carry/borrow ripples through every
  // digit combinationally so the full update lands on a single edge.
  // step_term flags that the stepped value is the terminal for the direction.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    logic [3:0] mx;
    logic [3:0] nd;
    step_val  = count_q;
    step_term = 1'b1;
    carry     = 1'b1;
    dig       = 4'd0;
    mx        = 4'd0;
    nd        = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      mx  = DIGIT_MAX[4*i +: 4];
      nd  = dig;
      if (carry) begin
        if (!bus.dir) begin
          if (dig >= mx) begin
            nd = 4'd0;
          end else begin
            nd    = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            nd = mx;
          end else begin
            nd    = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      step_val[4*i +: 4] = nd;
      if (bus.dir ? (nd != 4'd0) : (nd != mx)) step_term = 1'b0;
    end
  end

  // Control and next-state. A tick only counts in RUN when nothing of higher
  // priority (clear, load, a start/stop transition) happens in the same cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tc_d       = 1'b0;
    lap_hold_d = lap_hold_q ^ bus.lap;
    do_tick    = 1'b0;
    if (bus.sft_clr) begin
      state_d    = IDLE;
      count_d    = '0;
      lap_hold_d = 1'b0;
    end else if (bus.load) begin
      state_d = IDLE;
      count_d = clamp_bcd(bus.load_val);
    end else begin
      case (state_q)
        IDLE, PAUSE: if (bus.start && !bus.stop) state_d = RUN;
        RUN: begin
          if (bus.stop && !bus.start) state_d = PAUSE;
          else                        do_tick = bus.tick;
        end
        default: ;
      endcase
      if (do_tick) begin
        count_d = step_val;
        tc_d    = step_term;
        if (step_term && !WRAP) state_d = DONE;
      end
    end
    // Frozen display holds its value; otherwise it trails count by one cycle,
    // which also makes the capture on the lap edge take the current count.
    disp_d = (lap_hold_q && !bus.lap && !bus.sft_clr) ? disp_q : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      disp_q     <= '0;
      tc_q       <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
      tc_q       <= tc_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.disp     = disp_q;
  assign bus.tc       = tc_q;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.lap_hold = lap_hold_q;
endmodule

// File: tb/tb_bcd_timer_chain.sv
module tb_bcd_timer_chain;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_timer_chain_if #(.NUM_DIGITS(4)) ifa ();
  bcd_timer_chain_if #(.NUM_DIGITS(4)) ifw ();

  bcd_timer_chain #(.NUM_DIGITS(4), .DIGIT_MAX(32'h0000_5959), .WRAP(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  bcd_timer_chain #(.NUM_DIGITS(4), .DIGIT_MAX(32'h0000_5959), .WRAP(1'b0)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Seconds since 00:00 -> packed BCD mm:ss
  function automatic logic [15:0] mmss(input int n);
    int m;
    int s;
    m = n / 60;
    s = n % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    ifa.tick = 0; ifa.start = 0; ifa.stop = 0; ifa.dir = 0; ifa.load = 0;
    ifa.load_val = '0; ifa.sft_clr = 0; ifa.lap = 0;
    ifw.tick = 0; ifw.start = 0; ifw.stop = 0; ifw.dir = 0; ifw.load = 0;
    ifw.load_val = '0; ifw.sft_clr = 0; ifw.lap = 0;
    cyc();
    cyc();
    chk("rst_count", 32'(ifa.count), 32'h0);
    chk("rst_disp", 32'(ifa.disp), 32'h0);
    chk("rst_tc", 32'(ifa.tc), 32'h0);
    chk("rst_running", 32'(ifa.running), 32'h0);
    chk("rst_done", 32'(ifa.done), 32'h0);
    chk("rst_lap", 32'(ifa.lap_hold), 32'h0);
    rst_n = 1'b0;

    // WRAP=0 count-down to terminal
    ifw.dir = 1;
    ifw.load = 1; ifw.load_val = 16'h0003; cyc(); ifw.load = 0;
    chk("w_load", 32'(ifw.count), 32'h0003);
    ifw.start = 1; cyc(); ifw.start = 0;
    chk("w_run", 32'(ifw.running), 32'h1);
    ifw.tick = 1;
    cyc(); chk("w_t1", 32'(ifw.count), 32'h0002); chk("w_t1_tc", 32'(ifw.tc), 32'h0);
    cyc(); chk("w_t2", 32'(ifw.count), 32'h0001);
    cyc(); chk("w_t3", 32'(ifw.count), 32'h0000); chk("w_t3_tc", 32'(ifw.tc), 32'h1);
    chk("w_t3_done", 32'(ifw.done), 32'h1);
    cyc(); chk("w_t4", 32'(ifw.count), 32'h0000); chk("w_t4_tc", 32'(ifw.tc), 32'h0);
    chk("w_t4_done", 32'(ifw.done), 32'h1);
    ifw.tick = 0;
    ifw.start = 1; cyc(); ifw.start = 0;
    chk("w_start_in_done", 32'(ifw.done), 32'h1);
    // load of terminal value, then first tick crosses terminal without tc
    ifw.load = 1; ifw.load_val = 16'h0000; cyc(); ifw.load = 0;
    chk("w_load_term_tc", 32'(ifw.tc), 32'h0);
    chk("w_load_idle", 32'(ifw.done), 32'h0);
    ifw.start = 1; cyc(); ifw.start = 0;
    ifw.tick = 1; cyc(); ifw.tick = 0;
    chk("w_wrap_dn", 32'(ifw.count), 32'h5959);
    chk("w_wrap_tc", 32'(ifw.tc), 32'h0);
    chk("w_wrap_run", 32'(ifw.running), 32'h1);
    ifw.tick = 1; cyc(); ifw.tick = 0;
    chk("w_dn_next", 32'(ifw.count), 32'h5958);

    // Full hour count-up with wrap
    ifa.start = 1; cyc(); ifa.start = 0;
    chk("a_run", 32'(ifa.running), 32'h1);
    ifa.tick = 1;
    for (int k = 1; k <= 3600; k++) begin
      cyc();
      chk("hr_count", 32'(ifa.count), 32'(mmss(k % 3600)));
      chk("hr_tc", 32'(ifa.tc), (k == 3599) ? 32'h1 : 32'h0);
    end
    ifa.tick = 0;
    chk("hr_disp", 32'(ifa.disp), 32'h5959);
    chk("hr_still_run", 32'(ifa.running), 32'h1);

    // Load/ripple/clamp
    ifa.load = 1; ifa.load_val = 16'h0959; cyc(); ifa.load = 0;
    chk("ld_0959", 32'(ifa.count), 32'h0959);
    chk("ld_idle", 32'(ifa.running), 32'h0);
    ifa.start = 1; cyc(); ifa.start = 0;
    ifa.tick = 1; cyc(); ifa.tick = 0;
    chk("ripple", 32'(ifa.count), 32'h1000);
    chk("ripple_tc", 32'(ifa.tc), 32'h0);
    ifa.load = 1; ifa.load_val = 16'h5959; cyc(); ifa.load = 0;
    chk("ld_term_tc", 32'(ifa.tc), 32'h0);
    ifa.load = 1; ifa.load_val = 16'h0A0F; cyc(); ifa.load = 0;
    chk("clamp", 32'(ifa.count), 32'h0909);

    // start/stop control
    ifa.start = 1; cyc(); ifa.start = 0;
    ifa.start = 1; ifa.stop = 1; cyc(); ifa.start = 0; ifa.stop = 0;
    chk("startstop", 32'(ifa.running), 32'h1);
    ifa.stop = 1; cyc(); ifa.stop = 0;
    chk("pause", 32'(ifa.running), 32'h0);
    ifa.tick = 1; repeat (5) cyc(); ifa.tick = 0;
    chk("pause_hold", 32'(ifa.count), 32'h0909);
    ifa.start = 1; cyc(); ifa.start = 0;
    chk("resume", 32'(ifa.running), 32'h1);
    ifa.tick = 1; cyc(); ifa.tick = 0;
    chk("resume_tick", 32'(ifa.count), 32'h0910);

    // Lap freeze
    ifa.load = 1; ifa.load_val = 16'h0012; cyc(); ifa.load = 0;
    ifa.start = 1; cyc(); ifa.start = 0;
    ifa.lap = 1; cyc(); ifa.lap = 0;
    chk("lap_on", 32'(ifa.lap_hold), 32'h1);
    chk("lap_disp", 32'(ifa.disp), 32'h0012);
    ifa.tick = 1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("lap_frozen", 32'(ifa.disp), 32'h0012);
    end
    ifa.tick = 0;
    chk("lap_under", 32'(ifa.count), 32'h0022);
    ifa.lap = 1; cyc(); ifa.lap = 0;
    chk("lap_off", 32'(ifa.lap_hold), 32'h0);
    cyc();
    chk("lap_release", 32'(ifa.disp), 32'h0022);

    // Dropped ticks, soft clear, reset mid-run
    ifa.load = 1; ifa.tick = 1; ifa.load_val = 16'h0100; cyc();
    ifa.load = 0; ifa.tick = 0;
    chk("ld_tick_drop", 32'(ifa.count), 32'h0100);
    ifa.start = 1; cyc(); ifa.start = 0;
    ifa.lap = 1; cyc(); ifa.lap = 0;
    chk("lap_on2", 32'(ifa.lap_hold), 32'h1);
    ifa.sft_clr = 1; ifa.tick = 1; cyc(); ifa.sft_clr = 0; ifa.tick = 0;
    chk("clr_tick_drop", 32'(ifa.count), 32'h0);
    chk("clr_lap", 32'(ifa.lap_hold), 32'h0);
    chk("clr_idle", 32'(ifa.running), 32'h0);
    ifa.start = 1; cyc(); ifa.start = 0;
    ifa.tick = 1; repeat (3) cyc(); ifa.tick = 0;
    chk("cnt3", 32'(ifa.count), 32'h0003);
    ifa.lap = 1; cyc(); ifa.lap = 0;
    ifa.tick = 1; cyc();
    chk("cnt4", 32'(ifa.count), 32'h0004);
    rst_n = 1'b1; cyc(); rst_n = 1'b0; ifa.tick = 0;
    chk("mid_rst_count", 32'(ifa.count), 32'h0);
    chk("mid_rst_disp", 32'(ifa.disp), 32'h0);
    chk("mid_rst_run", 32'(ifa.running), 32'h0);
    chk("mid_rst_lap", 32'(ifa.lap_hold), 32'h0);
    chk("mid_rst_tc", 32'(ifa.tc), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_timer_chain.md
Name: bcd_timer_chain

Overview:
Parametrised successor to the fixed four-digit seconds/minutes counter chain. Holds NUM_DIGITS BCD digits, each with its own modulus, as one registered chain. Adds up/down counting, preset load, run/pause/done control, a terminal-count pulse and a lap-freeze display copy. Sits between the 1 s pulse generator (tick) and the 7-segment digit mux (disp).

Parameters:
NUM_DIGITS, 4, number of BCD digits; legal range 1..8.
DIGIT_MAX, 32'h0000_5959, packed per-digit maximum; digit i uses bits [4i+3:4i]. Each field must be 1..9.
WRAP, 1, 1 = wrap at terminal value and keep running; 0 = stop at terminal value and enter DONE.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-HIGH (name kept for codebase consistency; the level is not inverted)
tick  in  1  one-cycle count-enable pulse
start  in  1  pulse: IDLE/PAUSE -> RUN
stop  in  1  pulse: RUN -> PAUSE
dir  in  1  0 = count up, 1 = count down; sampled on each tick
load  in  1  pulse: load load_val
load_val  in  4*NUM_DIGITS  preset value, packed BCD
sft_clr  in  1  soft clear to zero
lap  in  1  pulse: toggle lap freeze
count  out  4*NUM_DIGITS  live counter value
disp  out  4*NUM_DIGITS  display value (live, or frozen while lap_hold)
tc  out  1  one-cycle terminal-count pulse
running  out  1  state == RUN
done  out  1  state == DONE
lap_hold  out  1  lap freeze active

Behaviour:
- Reset (rst_n=1 at a clk edge): count=0, disp=0, tc=0, lap_hold=0, state=IDLE. Reset overrides every other input.
- Priority, highest first: rst_n, sft_clr, load, start/stop, tick.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE or PAUSE + start -> RUN.
  - RUN + stop -> PAUSE.
  - start and stop in the same cycle -> no state change.
  - start is ignored in RUN and in DONE.
  - sft_clr or load in any state -> IDLE.
  - RUN + terminal reached with WRAP=0 -> DONE.
- sft_clr: count=0 and lap_hold=0 on the next edge.
- load: count=load_val on the next edge. Any digit above its DIGIT_MAX field is clamped to that field. lap_hold is unchanged.
- Ticks are acted on only in RUN. A tick coincident with load, sft_clr or a state change is dropped.
- Tick, up (dir=0):
  - Digit 0 increments.
  - A digit equal to its max becomes 0 and carries into the next digit.
  - The full ripple across all digits completes in a single edge.
- Tick, down (dir=1):
  - Digit 0 decrements.
  - A digit equal to 0 becomes its max and borrows from the next digit.
- Terminal value: all digits at max when counting up; all digits 0 when counting down.
- When a tick moves count onto the terminal value, tc=1 for exactly that cycle, registered together with the new count.
  - WRAP=1: stay in RUN; the next tick wraps (up: all max -> 0; down: 0 -> all max). The wrap itself does not pulse tc.
  - WRAP=0: enter DONE and hold count; further ticks are ignored.
- A load of the terminal value does not pulse tc.
- In WRAP=0, starting from a count already at terminal: the first tick crosses the terminal (wraps), gives no tc, and leaves the state in RUN.
- A dir change takes effect at the next tick; there is no other side effect.
- Latency: tick at edge n gives the updated count after edge n. disp follows count one cycle later (registered).
- lap pulse toggles lap_hold.
  - While lap_hold=1, disp holds the count value from the cycle lap was asserted.
  - Counting continues underneath.
  - Releasing the freeze resumes disp = count with a 1-cycle lag.
- Reset asserted mid-count: all outputs reach their reset values on that edge; there is no partial state.

Test Plan:
1. Reset then start with NUM_DIGITS=4, DIGIT_MAX=5959, dir=0; apply 3600 ticks -> count runs 0000..5959. tc fires exactly once, on the tick that gives 5959. The next tick gives 0000 with tc=0.
2. WRAP=0, dir=1, load 0003, start, then 4 ticks -> count 0002, 0001, 0000 with tc=1 and done=1. The 4th tick leaves count 0000 and tc=0.
3. Load 0959 while running with dir=0, tick -> count 1000 (full ripple in one edge). Load 0A0F -> count clamps to 0909.
4. start and stop asserted together in RUN -> state stays RUN. stop alone, then 5 ticks -> count unchanged. start -> ticks resume.
5. At count 0012, pulse lap, then 10 ticks -> disp stays 0012 while count reaches 0022. Pulse lap -> disp equals 0022 one cycle later.
6. tick coincident with load or sft_clr -> tick dropped, count equals load_val or 0. Reset pulsed mid-RUN -> count=0, disp=0, IDLE, lap_hold=0 on that edge.
